// File: rtl/dmem_axil_bridge_pkg.sv
// Shared types and constants for the MEM-stage to AXI4-Lite bridge.
package dmem_axil_bridge_pkg;

    localparam int unsigned STALL_CNT_WIDTH = 32;
    localparam int unsigned RESP_WIDTH      = 2;

    localparam logic [RESP_WIDTH-1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [RESP_WIDTH-1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [RESP_WIDTH-1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [RESP_WIDTH-1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_D  = 3'd2,
        ST_WR_AW = 3'd3,
        ST_WR_B  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Anything other than OKAY (EXOKAY included) is reported to the core as a bus error.
    function automatic logic resp_is_err(input logic [RESP_WIDTH-1:0] resp);
        return (resp == AXI_RESP_EXOKAY) || (resp == AXI_RESP_SLVERR) ||
               (resp == AXI_RESP_DECERR) || (resp != AXI_RESP_OKAY);
    endfunction

endpackage

// File: rtl/dmem_axil_bridge.sv
// MEM-stage data access to AXI4-Lite master bridge; stalls the pipeline per access.
module dmem_axil_bridge
    import dmem_axil_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          ALIGN_ADDR = 1'b1
) (
    input  logic                          aclk,
    input  logic                          areset,
    // MEM-stage side
    input  logic                          mem_r,
    input  logic                          mem_w,
    input  logic [(DATA_WIDTH/8)-1:0]     mem_w_strb,
    input  logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic [DATA_WIDTH-1:0]         mem_w_data,
    output logic [DATA_WIDTH-1:0]         mem_r_data,
    output logic                          mem_stall,
    output logic                          bus_err,
    output logic [STALL_CNT_WIDTH-1:0]    stall_cnt,
    // AW channel
    output logic [ADDR_WIDTH-1:0]         m_awaddr,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    // W channel
    output logic [DATA_WIDTH-1:0]         m_wdata,
    output logic [(DATA_WIDTH/8)-1:0]     m_wstrb,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    // B channel
    input  logic [RESP_WIDTH-1:0]         m_bresp,
    input  logic                          m_bvalid,
    output logic                          m_bready,
    // AR channel
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    // R channel
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic [RESP_WIDTH-1:0]         m_rresp,
    input  logic                          m_rvalid,
    output logic                          m_rready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    // Only a 32-bit data path is supported.
    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("dmem_axil_bridge: DATA_WIDTH must be 32");
        end
    endgenerate

    state_e                       r_state,   w_state_nxt;
    logic [ADDR_WIDTH-1:0]        r_awaddr,  w_awaddr_nxt;
    logic                         r_awvalid, w_awvalid_nxt;
    logic [DATA_WIDTH-1:0]        r_wdata,   w_wdata_nxt;
    logic [STRB_WIDTH-1:0]        r_wstrb,   w_wstrb_nxt;
    logic                         r_wvalid,  w_wvalid_nxt;
    logic                         r_bready,  w_bready_nxt;
    logic [ADDR_WIDTH-1:0]        r_araddr,  w_araddr_nxt;
    logic                         r_arvalid, w_arvalid_nxt;
    logic                         r_rready,  w_rready_nxt;
    logic [DATA_WIDTH-1:0]        r_rdata,   w_rdata_nxt;
    logic                         r_bus_err, w_bus_err_nxt;
    logic                         r_aw_done, w_aw_done_nxt;
    logic                         r_w_done,  w_w_done_nxt;
    logic [STALL_CNT_WIDTH-1:0]   r_stall_cnt;

    logic [ADDR_WIDTH-1:0]        w_req_addr;
    logic                         w_aw_hs;
    logic                         w_w_hs;
    logic                         w_stall;

    // Word-aligned or raw request address, selected at elaboration.
    assign w_req_addr = ALIGN_ADDR ? {mem_addr[ADDR_WIDTH-1:2], 2'b00} : mem_addr;
    assign w_aw_hs    = r_awvalid & m_awready;
    assign w_w_hs     = r_wvalid  & m_wready;

    // Request cycle and every bus-wait state stall; DONE releases the pipeline once.
    assign w_stall = ((r_state == ST_IDLE) && (mem_r || mem_w)) ||
                     ((r_state != ST_IDLE) && (r_state != ST_DONE));

    // Next-state and next register values for the access sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_awaddr_nxt  = r_awaddr;
        w_awvalid_nxt = r_awvalid;
        w_wdata_nxt   = r_wdata;
        w_wstrb_nxt   = r_wstrb;
        w_wvalid_nxt  = r_wvalid;
        w_bready_nxt  = r_bready;
        w_araddr_nxt  = r_araddr;
        w_arvalid_nxt = r_arvalid;
        w_rready_nxt  = r_rready;
        w_rdata_nxt   = r_rdata;
        w_bus_err_nxt = 1'b0;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;

        case (r_state)
            ST_IDLE: begin
                if (mem_w) begin
                    w_state_nxt   = ST_WR_AW;
                    w_awaddr_nxt  = w_req_addr;
                    w_wdata_nxt   = mem_w_data;
                    w_wstrb_nxt   = mem_w_strb;
                    w_awvalid_nxt = 1'b1;
                    w_wvalid_nxt  = 1'b1;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                end else if (mem_r) begin
                    w_state_nxt   = ST_RD_A;
                    w_araddr_nxt  = w_req_addr;
                    w_arvalid_nxt = 1'b1;
                end
            end
            ST_RD_A: begin
                if (m_arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = ST_RD_D;
                end
            end
            ST_RD_D: begin
                if (m_rvalid) begin
                    w_rdata_nxt   = m_rdata;
                    w_rready_nxt  = 1'b0;
                    w_bus_err_nxt = resp_is_err(m_rresp);
                    w_state_nxt   = ST_DONE;
                end
            end
            ST_WR_AW: begin
                if (w_aw_hs) begin
                    w_awvalid_nxt = 1'b0;
                    w_aw_done_nxt = 1'b1;
                end
                if (w_w_hs) begin
                    w_wvalid_nxt = 1'b0;
                    w_w_done_nxt = 1'b1;
                end
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = ST_WR_B;
                end
            end
            ST_WR_B: begin
                if (m_bvalid) begin
                    w_bready_nxt  = 1'b0;
                    w_bus_err_nxt = resp_is_err(m_bresp);
                    w_state_nxt   = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered bus/pipeline outputs.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state   <= ST_IDLE;
            r_awaddr  <= '0;
            r_awvalid <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_araddr  <= '0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_rdata   <= '0;
            r_bus_err <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_awaddr  <= w_awaddr_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wstrb   <= w_wstrb_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_bready  <= w_bready_nxt;
            r_araddr  <= w_araddr_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
            r_rdata   <= w_rdata_nxt;
            r_bus_err <= w_bus_err_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
        end
    end

    // Free-running count of stalled cycles, wrapping.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_WIDTH'(1);
        end
    end

    assign mem_stall  = w_stall;
    assign mem_r_data = r_rdata;
    assign bus_err    = r_bus_err;
    assign stall_cnt  = r_stall_cnt;
    assign m_awaddr   = r_awaddr;
    assign m_awvalid  = r_awvalid;
    assign m_wdata    = r_wdata;
    assign m_wstrb    = r_wstrb;
    assign m_wvalid   = r_wvalid;
    assign m_bready   = r_bready;
    assign m_araddr   = r_araddr;
    assign m_arvalid  = r_arvalid;
    assign m_rready   = r_rready;

endmodule
